// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: p_ram write port plus the CPU hold and load-status lines.
// The loader drives the master side; p_ram and the CPU reset logic take the slave side.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 15
);
  logic              pram_wren;
  logic [ADDR_W-1:0] pram_addr;
  logic [15:0]       pram_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output pram_wren, pram_addr, pram_data, cpu_hold, load_done, load_err
  );

  modport slave (
    input  pram_wren, pram_addr, pram_data, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives an XM23 image over 8N1 UART and writes it into p_ram while holding the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module uart_prog_loader #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 15
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               uart_rx,
  input  logic               start,
  uart_prog_loader_if.master bus
);

  localparam int BIT_TICKS  = CLK_HZ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int TICK_W     = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE, ERR} state_t;
  localparam state_t IMAGE_END = CHECK;
`else
  typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, DONE, ERR} state_t;
  localparam state_t IMAGE_END = DONE;
`endif

  logic              rx_meta, rx_sync, rx_prev;
  rx_state_t         rx_state, rx_next;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        rx_byte;
  logic              tick_done, half_done, rx_fall;
  logic              byte_valid, frame_err;

  state_t            state, next_state;
  logic [7:0]        len_lo_q, lo_q;
  logic [15:0]       len_q;
  logic [15:0]       len_in;
  logic [ADDR_W:0]   word_cnt;
  logic              last_word, len_too_long;
  logic              wren_q, hold_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;

  assign tick_done  = (tick_cnt == TICK_LAST);
  assign half_done  = (tick_cnt == HALF_LAST);
  assign rx_fall    = rx_prev & ~rx_sync;
  assign byte_valid = (rx_state == RX_STOP) && tick_done && rx_sync;
  assign frame_err  = (rx_state == RX_STOP) && tick_done && !rx_sync;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (half_done) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_done && (bit_idx == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (tick_done) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timer restarts at mid start bit so every later sample lands mid-bit.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_next;
      if ((rx_state == RX_IDLE) || ((rx_state == RX_START) && half_done) || tick_done)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;
      if ((rx_state == RX_START) && half_done)
        bit_idx <= '0;
      else if ((rx_state == RX_DATA) && tick_done) begin
        rx_byte <= {rx_sync, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign len_in       = {rx_byte, len_lo_q};
  assign len_too_long = 32'(len_in) > (32'd1 << ADDR_W);
  assign last_word    = (32'(word_cnt) + 32'd1) == 32'(len_q);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)
      csum_q <= '0;
    else if (start || (state == SYNC))
      csum_q <= '0;
    else if (byte_valid && ((state == DATA_LO) || (state == DATA_HI)))
      csum_q <= csum_q ^ rx_byte;
  end
`endif

  // start outranks everything, so a byte arriving with it is dropped.
  always_comb begin
    next_state = state;
    if (start)
      next_state = SYNC;
    else if (frame_err) begin
      if (state != DONE) next_state = ERR;
    end else begin
      case (state)
        SYNC:    if (byte_valid && (rx_byte == 8'hA5)) next_state = LEN_LO;
        LEN_LO:  if (byte_valid) next_state = LEN_HI;
        LEN_HI:
          if (byte_valid) begin
            if (len_in == 16'd0)  next_state = IMAGE_END;
            else if (len_too_long) next_state = ERR;
            else                   next_state = DATA_LO;
          end
        DATA_LO: if (byte_valid) next_state = DATA_HI;
        DATA_HI: if (wren_q) next_state = last_word ? IMAGE_END : DATA_LO;
`ifdef LOADER_CHECKSUM_EN
        CHECK:   if (byte_valid) next_state = (rx_byte == csum_q) ? DONE : ERR;
`endif
        default: next_state = state;
      endcase
    end
  end

  // Status flags are registered from next_state so cpu_hold only moves on the clock edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= SYNC;
      len_lo_q <= '0;
      len_q    <= '0;
      lo_q     <= '0;
      word_cnt <= '0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= next_state;
      wren_q <= 1'b0;
      hold_q <= (next_state != DONE);
      done_q <= (next_state == DONE);
      err_q  <= (next_state == ERR);
      if (start) begin
        addr_q   <= '0;
        word_cnt <= '0;
      end else begin
        if (wren_q) begin
          addr_q   <= addr_q + 1'b1;
          word_cnt <= word_cnt + 1'b1;
        end
        if (byte_valid) begin
          case (state)
            LEN_LO:  len_lo_q <= rx_byte;
            LEN_HI:  len_q    <= len_in;
            DATA_LO: lo_q     <= rx_byte;
            DATA_HI: begin
              data_q <= {rx_byte, lo_q};
              wren_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.pram_wren = wren_q;
  assign bus.pram_addr = addr_q;
  assign bus.pram_data = data_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed UART image loads against uart_prog_loader with hand-computed results.
// Runs with a fast baud (10 clocks per bit); honours LOADER_CHECKSUM_EN when defined.
module tb_uart_prog_loader;

  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD      = 5_000_000;
  localparam int ADDR_W    = 15;
  localparam int BIT_TICKS = CLK_HZ / BAUD;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic uart_rx = 1'b1;
  logic start  = 1'b0;

  int pass_count  = 0;
  int check_count = 0;

  int cyc = 0;
  int wr_count = 0;
  int wren_long = 0;
  int last_wr_cycle = 0;
  int release_cycle = 0;
  logic prev_wren = 1'b0;
  logic prev_hold = 1'b1;
  logic [ADDR_W-1:0] wr_addr [64];
  logic [15:0]       wr_data [64];

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) pram_bus ();

  uart_prog_loader #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .uart_rx (uart_rx),
    .start   (start),
    .bus     (pram_bus.master)
  );

  always #5 clk_in = ~clk_in;

  // Write log and cpu_hold release timing, sampled on the inactive edge.
  always @(negedge clk_in) begin
    cyc       <= cyc + 1;
    prev_wren <= pram_bus.pram_wren;
    prev_hold <= pram_bus.cpu_hold;
    if (pram_bus.pram_wren === 1'b1) begin
      wr_addr[wr_count[5:0]] <= pram_bus.pram_addr;
      wr_data[wr_count[5:0]] <= pram_bus.pram_data;
      wr_count      <= wr_count + 1;
      last_wr_cycle <= cyc;
      if (prev_wren === 1'b1) wren_long <= wren_long + 1;
    end
    if ((prev_hold === 1'b1) && (pram_bus.cpu_hold === 1'b0)) release_cycle <= cyc;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT_TICKS) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_TICKS) @(negedge clk_in);
    end
    uart_rx = stop_bit;
    repeat (BIT_TICKS) @(negedge clk_in);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic pulseStart();
    @(negedge clk_in) start = 1'b1;
    @(negedge clk_in) start = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " wren"}, 32'(pram_bus.pram_wren), 32'd0);
    checkOutput({tag, " addr"}, 32'(pram_bus.pram_addr), 32'd0);
    checkOutput({tag, " data"}, 32'(pram_bus.pram_data), 32'd0);
    checkOutput({tag, " cpu_hold"}, 32'(pram_bus.cpu_hold), 32'd1);
    checkOutput({tag, " load_done"}, 32'(pram_bus.load_done), 32'd0);
    checkOutput({tag, " load_err"}, 32'(pram_bus.load_err), 32'd0);
  endtask

  // Two-word image A5 02 00 34 12 78 56; XOR of data bytes is 0x08.
  task automatic runTwoWordImage(input string tag);
    int base;
    base = wr_count;
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h78, 1'b1);
    applyStimulus(8'h56, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'h08, 1'b1);
`endif
    repeat (4) @(negedge clk_in);
    checkOutput({tag, " writes"}, 32'(wr_count - base), 32'd2);
    checkOutput({tag, " addr0"}, 32'(wr_addr[base[5:0]]), 32'd0);
    checkOutput({tag, " data0"}, 32'(wr_data[base[5:0]]), 32'h1234);
    checkOutput({tag, " addr1"}, 32'(wr_addr[6'(base + 1)]), 32'd1);
    checkOutput({tag, " data1"}, 32'(wr_data[6'(base + 1)]), 32'h5678);
    checkOutput({tag, " load_done"}, 32'(pram_bus.load_done), 32'd1);
    checkOutput({tag, " cpu_hold"}, 32'(pram_bus.cpu_hold), 32'd0);
    checkOutput({tag, " load_err"}, 32'(pram_bus.load_err), 32'd0);
    checkOutput({tag, " final addr"}, 32'(pram_bus.pram_addr), 32'd2);
    checkOutput({tag, " held data"}, 32'(pram_bus.pram_data), 32'h5678);
`ifndef LOADER_CHECKSUM_EN
    checkOutput({tag, " release lag"}, 32'(release_cycle - last_wr_cycle), 32'd1);
`endif
  endtask

  initial begin
    int base;
    logic [7:0] partial;

    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    checkResetValues("reset");

    $display("[TB] test 1: two-word image");
    runTwoWordImage("t1");

    $display("[TB] test 2: leading junk, empty image");
    pulseStart();
    checkOutput("t2 start done", 32'(pram_bus.load_done), 32'd0);
    checkOutput("t2 start hold", 32'(pram_bus.cpu_hold), 32'd1);
    checkOutput("t2 start addr", 32'(pram_bus.pram_addr), 32'd0);
    base = wr_count;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'h00, 1'b1);
`endif
    repeat (4) @(negedge clk_in);
    checkOutput("t2 writes", 32'(wr_count - base), 32'd0);
    checkOutput("t2 load_done", 32'(pram_bus.load_done), 32'd1);
    checkOutput("t2 cpu_hold", 32'(pram_bus.cpu_hold), 32'd0);
    checkOutput("t2 load_err", 32'(pram_bus.load_err), 32'd0);

    $display("[TB] test 3: framing error then restart");
    pulseStart();
    base = wr_count;
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b0);
    repeat (4) @(negedge clk_in);
    checkOutput("t3 load_err", 32'(pram_bus.load_err), 32'd1);
    checkOutput("t3 cpu_hold", 32'(pram_bus.cpu_hold), 32'd1);
    checkOutput("t3 load_done", 32'(pram_bus.load_done), 32'd0);
    checkOutput("t3 writes", 32'(wr_count - base), 32'd0);
    pulseStart();
    checkOutput("t3 err cleared", 32'(pram_bus.load_err), 32'd0);
    runTwoWordImage("t3 rerun");

    $display("[TB] test 4: reset during word 1 high byte");
    pulseStart();
    base = wr_count;
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h78, 1'b1);
    checkOutput("t4 word0 written", 32'(wr_count - base), 32'd1);
    partial = 8'h56;
    uart_rx = 1'b0;
    repeat (BIT_TICKS) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      uart_rx = partial[i];
      repeat (BIT_TICKS) @(negedge clk_in);
    end
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk_in);
    checkResetValues("t4 in reset");
    reset = 1'b0;
    base  = wr_count;
    repeat (3 * BIT_TICKS) @(negedge clk_in);
    checkResetValues("t4 after reset");
    checkOutput("t4 no writes", 32'(wr_count - base), 32'd0);
    runTwoWordImage("t4 reload");

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] test 5: checksum good and bad");
    pulseStart();
    base = wr_count;
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h26, 1'b1);
    repeat (4) @(negedge clk_in);
    checkOutput("t5 writes", 32'(wr_count - base), 32'd1);
    checkOutput("t5 data", 32'(wr_data[base[5:0]]), 32'h1234);
    checkOutput("t5 load_done", 32'(pram_bus.load_done), 32'd1);
    pulseStart();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h27, 1'b1);
    repeat (4) @(negedge clk_in);
    checkOutput("t5 bad load_err", 32'(pram_bus.load_err), 32'd1);
    checkOutput("t5 bad cpu_hold", 32'(pram_bus.cpu_hold), 32'd1);
`endif

    $display("[TB] test 6: length above 2**ADDR_W");
    pulseStart();
    base = wr_count;
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h80, 1'b1);
    repeat (4) @(negedge clk_in);
    checkOutput("t6 load_err", 32'(pram_bus.load_err), 32'd1);
    checkOutput("t6 cpu_hold", 32'(pram_bus.cpu_hold), 32'd1);
    checkOutput("t6 load_done", 32'(pram_bus.load_done), 32'd0);
    checkOutput("t6 writes", 32'(wr_count - base), 32'd0);

    checkOutput("wren single cycle", 32'(wren_long), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
